// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: address/instruction widths and opcode encodings.
package mips_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 32;
   localparam int unsigned INSTR_W        = 32;
   localparam int unsigned OP_W           = 6;

   localparam logic [OP_W-1:0] OP_R    = 6'd0;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'd4;
   localparam logic [OP_W-1:0] OP_ADDI = 6'd8;
   localparam logic [OP_W-1:0] OP_LW   = 6'd35;
   localparam logic [OP_W-1:0] OP_SW   = 6'd43;

   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

   // Major opcode field of an instruction word.
   function automatic logic [OP_W-1:0] opcode(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1:INSTR_W-OP_W];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      empty   = (count == '0);
      full    = (count == CNT_W'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && !full;
      head    = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order response buffering,
// redirect squash via a discard counter, and a valid/ready instruction port to decode.
module instr_fetch
   import mips_pkg::*;
#(
   parameter int unsigned        ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int unsigned        DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [5:0]        op,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  rsp_pc;
   logic [ADDR_W-1:0]  redirect_aligned;
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   inflight_nxt;
   logic [CNT_W-1:0]   discard;
   logic [CNT_W-1:0]   count;
   logic [CNT_W:0]     credit_used;
   logic               accept;
   logic               rsp_keep;
   logic               pop;
   logic               full;
   logic               empty;
   logic [ENTRY_W-1:0] head;
   logic [INSTR_W-1:0] instr_hold;
   logic [ADDR_W-1:0]  pc_hold;

   // Request credit, response filtering and counter arithmetic.
   always_comb begin
      redirect_aligned = redirect_pc & ~ADDR_W'(3);
      credit_used      = {1'b0, count} + {1'b0, inflight};
      imem_req_valid   = !reset && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
      imem_req_addr    = pc;
      accept           = imem_req_valid && imem_req_ready;
      rsp_keep         = imem_rsp_valid && (discard == '0) && !redirect_valid;
      pop              = instr_valid && instr_ready;
      inflight_nxt     = inflight + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
   end

   // rsp_pc shadows the address of the next response that will be kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else begin
         inflight <= inflight_nxt;
         if (redirect_valid) begin
            pc      <= redirect_aligned;
            rsp_pc  <= redirect_aligned;
            discard <= inflight_nxt;
         end else begin
            if (accept) pc <= pc + ADDR_W'(4);
            if (imem_rsp_valid && (discard != '0)) discard <= discard - CNT_W'(1);
            if (rsp_keep) rsp_pc <= rsp_pc + ADDR_W'(4);
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data ({rsp_pc, imem_rsp_data}),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Remembers the last presented entry so the decode port holds its value while empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_hold <= NOP_WORD;
         pc_hold    <= '0;
      end else if (!empty) begin
         instr_hold <= head[INSTR_W-1:0];
         pc_hold    <= head[ENTRY_W-1:INSTR_W];
      end
   end

   always_comb begin
      instr_valid = !empty;
      instr       = empty ? instr_hold : head[INSTR_W-1:0];
      instr_pc    = empty ? pc_hold : head[ENTRY_W-1:INSTR_W];
      op          = opcode(instr);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(rsp_keep && full));
         assert (!(imem_rsp_valid && (inflight == '0)));
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: in-order memory model, expected-PC queue, decode monitor.
`timescale 1ns/1ps
module tb_instr_fetch;
   import mips_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;
   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic [5:0]        op;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instr_fetch #(
      .ADDR_W   (ADDR_W),
      .RESET_PC ('0),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .op             (op),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Memory contents: opcode chosen by word index, low bits carry the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [5:0] o;
      case (a[4:2])
         3'd0:    o = OP_R;
         3'd1:    o = OP_BEQ;
         3'd2:    o = OP_ADDI;
         3'd3:    o = OP_LW;
         3'd4:    o = OP_SW;
         3'd5:    o = 6'd2;
         3'd6:    o = 6'd13;
         default: o = 6'd63;
      endcase
      return {o, a[27:2]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // In-order memory model with fixed latency and a response hold switch.
   typedef struct {
      logic [31:0] addr;
      int          rem;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] acc_log[$];
   int          acc_cnt  = 0;
   int          mem_lat  = 1;
   logic        mem_hold = 1'b0;
   logic        mem_have = 1'b0;
   logic [31:0] mem_data = 32'h0;

   assign imem_rsp_valid = mem_have && !mem_hold;
   assign imem_rsp_data  = mem_data;

   always begin
      logic        s_acc;
      logic        s_taken;
      logic        s_rst;
      logic [31:0] s_addr;
      @(negedge clk);
      s_rst   = reset;
      s_acc   = imem_req_valid && imem_req_ready && !reset;
      s_addr  = imem_req_addr;
      s_taken = imem_rsp_valid && !reset;
      @(posedge clk);
      #1;
      if (s_rst) begin
         mq.delete();
      end else begin
         if (s_taken) void'(mq.pop_front());
         foreach (mq[i]) if (mq[i].rem > 0) mq[i].rem--;
         if (s_acc) begin
            mq.push_back('{addr: s_addr, rem: mem_lat - 1});
            acc_log.push_back(s_addr);
            acc_cnt++;
         end
      end
      mem_have = (mq.size() > 0) && (mq[0].rem == 0);
      mem_data = mem_have ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
   end

   // Decode-side monitor: every handshake pops one expected PC.
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      logic [31:0] e;
      logic [31:0] w;
      if (!reset && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_instr: got pc %h with nothing expected", instr_pc);
         end else begin
            e = exp_q.pop_front();
            w = mem_word(e);
            check("instr_pc", instr_pc, e);
            check("instr", instr, w);
            check("op", 32'(op), 32'(w[31:26]));
         end
      end
   end

   task automatic drain(input string name);
      int b = 0;
      instr_ready = 1'b1;
      while (exp_q.size() != 0 && b < 200) begin
         tick();
         b++;
      end
      instr_ready = 1'b0;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d entries left expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic hard_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      mem_hold       = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rec;
      int          a0;
      int          b;

      imem_req_ready = 1'b1;
      redirect_pc    = '0;
      hard_reset();

      // Reset state
      @(negedge clk);
      check("rst_req_valid", 32'(imem_req_valid), 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_op", 32'(op), 32'h0);
      tick();
      reset = 1'b0;
      acc_log.delete();
      @(negedge clk);
      check("first_req_valid", 32'(imem_req_valid), 32'h1);
      check("first_req_addr", imem_req_addr, 32'h0);
      tick();

      // 1: sequential stream
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      drain("t1");
      for (int i = 0; i < 4; i++) begin
         rec = (acc_log.size() > i) ? acc_log[i] : 32'hFFFF_FFFF;
         check("t1_req_addr", rec, 32'(i * 4));
      end

      // 2: decode stalled for 10 cycles
      a0 = acc_cnt;
      rec = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 3) rec = instr;
         if (i >= 3) begin
            check("t2_stable_instr", instr, rec);
            check("t2_valid_held", 32'(instr_valid), 32'h1);
         end
         tick();
      end
      check("t2_instr_pc", instr_pc, 32'h20);
      check("t2_credit", 32'((acc_cnt - a0) <= int'(DEPTH)), 32'h1);
      for (int i = 8; i < 12; i++) exp_q.push_back(32'(i * 4));
      drain("t2");

      // 3: redirect with two requests in flight
      hard_reset();
      mem_hold = 1'b1;
      reset    = 1'b0;
      acc_log.delete();
      a0 = acc_cnt;
      b  = 0;
      while ((acc_cnt - a0) < 2 && b < 20) begin
         tick();
         b++;
      end
      tick();
      tick();
      check("t3_inflight", 32'(acc_cnt - a0), 32'h2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h103;
      @(negedge clk);
      check("t3_redir_req_valid", 32'(imem_req_valid), 32'h0);
      tick();
      redirect_valid = 1'b0;
      mem_hold       = 1'b0;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      drain("t3");
      rec = (acc_log.size() > 2) ? acc_log[2] : 32'hFFFF_FFFF;
      check("t3_req_after_redirect", rec, 32'h100);

      // 4: redirect coinciding with a response and a pop
      hard_reset();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      mem_hold    = 1'b1;
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      instr_ready    = 1'b1;
      mem_hold       = 1'b0;
      @(negedge clk);
      check("t4_rsp_same_cycle", 32'(imem_rsp_valid), 32'h1);
      check("t4_pop_valid", 32'(instr_valid), 32'h1);
      check("t4_redir_req_valid", 32'(imem_req_valid), 32'h0);
      tick();
      redirect_valid = 1'b0;
      instr_ready    = 1'b0;
      @(negedge clk);
      check("t4_empty_after", 32'(instr_valid), 32'h0);
      tick();
      drain("t4");

      // 5: PC wrap at top of address space
      hard_reset();
      reset          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      acc_log.delete();
      tick();
      redirect_valid = 1'b0;
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      drain("t5");
      rec = (acc_log.size() > 0) ? acc_log[0] : 32'h1;
      check("t5_req_top", rec, 32'hFFFF_FFFC);
      rec = (acc_log.size() > 1) ? acc_log[1] : 32'h1;
      check("t5_req_wrap", rec, 32'h0);

      // 6: reset with a full buffer
      for (int i = 0; i < 8; i++) tick();
      @(negedge clk);
      check("t6_full_valid", 32'(instr_valid), 32'h1);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      check("t6_instr_valid", 32'(instr_valid), 32'h0);
      check("t6_req_valid", 32'(imem_req_valid), 32'h0);
      check("t6_req_addr", imem_req_addr, 32'h0);
      check("t6_instr", instr, 32'h0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("t6_restart_valid", 32'(imem_req_valid), 32'h1);
      check("t6_restart_addr", imem_req_addr, 32'h0);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
